id_ex_stage: RTL

- ID/EX pipeline register of the 5-stage CPU. Sits directly upstream of the 32-slice ripple ALU.
- Captures decoded ID-stage operands and control on each clock.
- Generates the ALU slice controls from opcode/funct and registers them: 3-bit sel, Binvert/carry-in.
- Handles hazard-unit stall and flush, and counts inserted bubbles for debug.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/alu_ctrl_decode.sv | 69 ++++++
 rtl/id_ex_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: ALU op encodings, opcode/funct
// values and the control bundle carried from decode into ID/EX.
package cpu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [2:0] alu_sel;
        logic       binvert;
        logic       alu_src;
        logic       dst_rd;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       branch;
        logic       illegal;
    } ctrl_t;

    // Bubble: an ADD that writes nothing and touches no memory.
    localparam ctrl_t CTRL_BUBBLE = '{
        alu_sel:    ALU_ADD,
        binvert:    1'b0,
        alu_src:    1'b0,
        dst_rd:     1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        illegal:    1'b0
    };

    function automatic logic binvert_of(input logic [2:0] sel);
        return (sel == ALU_SUB) || (sel == ALU_SLT);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of opcode/funct into ALU slice controls and
// pipeline control bits; unsupported encodings raise illegal.
module alu_ctrl_decode
    import cpu_pkg::*;
(
    input  logic [5:0] opcode_in,
    input  logic [5:0] funct_in,
    output ctrl_t      ctrl_out
);

    ctrl_t w_ctrl;

    // Opcode/funct lookup; binvert derived from the chosen ALU op.
    always_comb begin
        w_ctrl = CTRL_BUBBLE;
        case (opcode_in)
            OP_RTYPE: begin
                w_ctrl.dst_rd    = 1'b1;
                w_ctrl.reg_write = 1'b1;
                case (funct_in)
                    FN_ADD:  w_ctrl.alu_sel = ALU_ADD;
                    FN_SUB:  w_ctrl.alu_sel = ALU_SUB;
                    FN_AND:  w_ctrl.alu_sel = ALU_AND;
                    FN_OR:   w_ctrl.alu_sel = ALU_OR;
                    FN_SLT:  w_ctrl.alu_sel = ALU_SLT;
                    default: begin
                        w_ctrl.reg_write = 1'b0;
                        w_ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                w_ctrl.alu_src    = 1'b1;
                w_ctrl.mem_read   = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.alu_sel = ALU_SUB;
                w_ctrl.branch  = 1'b1;
            end
            OP_ADDI: begin
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_SLTI: begin
                w_ctrl.alu_sel   = ALU_SLT;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_ORI: begin
                w_ctrl.alu_sel   = ALU_OR;
                w_ctrl.alu_src   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            default: begin
                w_ctrl.illegal = 1'b1;
            end
        endcase
        w_ctrl.binvert = binvert_of(w_ctrl.alu_sel);
    end

    assign ctrl_out = w_ctrl;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures operands and decoded ALU/pipeline
// controls, with flush/stall handling and a saturating bubble counter.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [5:0]        opcode_in,
    input  logic [5:0]        funct_in,
    input  logic [DATA_W-1:0] rs_data_in,
    input  logic [DATA_W-1:0] rt_data_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_AW-1:0] rs_in,
    input  logic [REG_AW-1:0] rt_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic              valid_out,
    output logic [2:0]        alu_sel,
    output logic              binvert,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] rt_data_out,
    output logic [REG_AW-1:0] rs_out,
    output logic [REG_AW-1:0] rt_out,
    output logic [REG_AW-1:0] dst_out,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              branch,
    output logic              illegal,
    output logic [CNT_W-1:0]  bubble_cnt
);

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_alu_b;
    logic [REG_AW-1:0] w_dst;

    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [DATA_W-1:0] r_rt_data;
    logic [REG_AW-1:0] r_rs;
    logic [REG_AW-1:0] r_rt;
    logic [REG_AW-1:0] r_dst;
    logic [CNT_W-1:0]  r_bubble_cnt;

    alu_ctrl_decode u_decode (
        .opcode_in (opcode_in),
        .funct_in  (funct_in),
        .ctrl_out  (w_ctrl)
    );

    assign w_alu_b = w_ctrl.alu_src ? imm_in : rt_data_in;
    assign w_dst   = w_ctrl.dst_rd  ? rd_in  : rt_in;

    // Pipeline register: rst > flush > stall > load; an invalid load is a
    // bubble that does not count toward bubble_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_ctrl       <= CTRL_BUBBLE;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_rt_data    <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_dst        <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_BUBBLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_rt_data <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dst     <= '0;
            if (r_bubble_cnt != {CNT_W{1'b1}}) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            r_valid <= r_valid;
        end else if (valid_in) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_alu_a   <= rs_data_in;
            r_alu_b   <= w_alu_b;
            r_rt_data <= rt_data_in;
            r_rs      <= rs_in;
            r_rt      <= rt_in;
            r_dst     <= w_dst;
        end else begin
            r_valid   <= 1'b0;
            r_ctrl    <= CTRL_BUBBLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_rt_data <= '0;
            r_rs      <= '0;
            r_rt      <= '0;
            r_dst     <= '0;
        end
    end

    assign valid_out   = r_valid;
    assign alu_sel     = r_ctrl.alu_sel;
    assign binvert     = r_ctrl.binvert;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign rt_data_out = r_rt_data;
    assign rs_out      = r_rs;
    assign rt_out      = r_rt;
    assign dst_out     = r_dst;
    assign reg_write   = r_ctrl.reg_write;
    assign mem_read    = r_ctrl.mem_read;
    assign mem_write   = r_ctrl.mem_write;
    assign mem_to_reg  = r_ctrl.mem_to_reg;
    assign branch      = r_ctrl.branch;
    assign illegal     = r_ctrl.illegal;
    assign bubble_cnt  = r_bubble_cnt;

endmodule
